// File: rtl/prng_lfsr_packer.sv
`default_nettype none
// ============================================================================
// Module      : prng_lfsr_packer
// Description : Reseedable 64-bit pseudo-random generator for register wiping.
//               Narrow entropy beats are packed (first beat in the LSBs) into
//               a 64-bit seed, which is loaded into a Galois-XOR LFSR
//               (x^64+x^63+x^61+x^60+1). The output is the LFSR state after
//               a bit permutation followed by a PRINCE S-box layer.
// Ports       : clk_i          - clock, rising edge
//               rst_i          - synchronous active-high reset
//               lfsr_en_i      - advance the LFSR one step
//               ent_valid_i    - entropy beat valid (always accepted)
//               ent_i          - entropy beat
//               seed_valid_o   - one-cycle pulse, seed loaded at this edge
//               seed_o         - packed seed (zero when not valid)
//               state_raw_o    - raw LFSR state
//               state_o        - permuted + S-boxed state
// Revision    : 1.0 - initial release
// ============================================================================
module prng_lfsr_packer #(
    parameter int               Width        = 64,
    parameter int               EntropyWidth = 32,
    parameter logic [63:0]      DefaultSeed  = 64'h0123_4567_89AB_CDEF,
    parameter logic [64*6-1:0]  StatePerm    = {
        6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58, 6'd57, 6'd56,
        6'd55, 6'd54, 6'd53, 6'd52, 6'd51, 6'd50, 6'd49, 6'd48,
        6'd47, 6'd46, 6'd45, 6'd44, 6'd43, 6'd42, 6'd41, 6'd40,
        6'd39, 6'd38, 6'd37, 6'd36, 6'd35, 6'd34, 6'd33, 6'd32,
        6'd31, 6'd30, 6'd29, 6'd28, 6'd27, 6'd26, 6'd25, 6'd24,
        6'd23, 6'd22, 6'd21, 6'd20, 6'd19, 6'd18, 6'd17, 6'd16,
        6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10, 6'd9,  6'd8,
        6'd7,  6'd6,  6'd5,  6'd4,  6'd3,  6'd2,  6'd1,  6'd0}
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    lfsr_en_i,
    input  logic                    ent_valid_i,
    input  logic [EntropyWidth-1:0] ent_i,
    output logic                    seed_valid_o,
    output logic [Width-1:0]        seed_o,
    output logic [Width-1:0]        state_raw_o,
    output logic [Width-1:0]        state_o
);

    localparam int          Beats = Width / EntropyWidth;
    localparam int          CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [63:0] Taps  = 64'hD800_0000_0000_0000;

    // Every output bit must be sourced by exactly one state bit.
    function automatic bit perm_is_bijection(input logic [64*6-1:0] perm);
        logic [63:0] seen;
        seen = '0;
        for (int i = 0; i < 64; i++) begin
            seen[perm[i*6 +: 6]] = 1'b1;
        end
        return &seen;
    endfunction

    // PRINCE S-box.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hB;  4'h1: y = 4'hF;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
            4'h4: y = 4'hA;  4'h5: y = 4'hC;  4'h6: y = 4'h9;  4'h7: y = 4'h1;
            4'h8: y = 4'h6;  4'h9: y = 4'h7;  4'hA: y = 4'h8;  4'hB: y = 4'h0;
            4'hC: y = 4'hE;  4'hD: y = 4'h5;  4'hE: y = 4'hD;  default: y = 4'h4;
        endcase
        return y;
    endfunction

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (Width != 64) begin : g_bad_width
        $error("prng_lfsr_packer: only Width=64 is supported");
    end
    if ((EntropyWidth <= 0) || (Width % EntropyWidth != 0)) begin : g_bad_ew
        $error("prng_lfsr_packer: EntropyWidth must divide Width");
    end
    if (DefaultSeed == 64'h0) begin : g_bad_seed
        $error("prng_lfsr_packer: DefaultSeed must be nonzero");
    end
    if (!perm_is_bijection(StatePerm)) begin : g_bad_perm
        $error("prng_lfsr_packer: StatePerm must be a bijection");
    end

    // ------------------------------------------------------------------
    // Entropy packer
    // ------------------------------------------------------------------
    logic [CntW-1:0]  beat_cnt;
    logic [Width-1:0] pack_word;
    logic [Width-1:0] pack_merged;
    logic             last_beat;
    logic             seed_valid;
    logic [Width-1:0] seed_word;

    always_comb begin
        pack_merged = pack_word;
        pack_merged[beat_cnt*EntropyWidth +: EntropyWidth] = ent_i;
    end

    assign last_beat = ent_valid_i && (beat_cnt == CntW'(Beats - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt   <= '0;
            pack_word  <= '0;
            seed_valid <= 1'b0;
            seed_word  <= '0;
        end else begin
            // The seed register is only non-zero during the pulse cycle.
            seed_valid <= last_beat;
            seed_word  <= last_beat ? pack_merged : '0;
            if (last_beat) begin
                // Consumer is always ready: the packer empties right away,
                // so a beat during the pulse is beat 0 of the next word.
                beat_cnt  <= '0;
                pack_word <= '0;
            end else if (ent_valid_i) begin
                beat_cnt  <= beat_cnt + 1'b1;
                pack_word <= pack_merged;
            end
        end
    end

    assign seed_valid_o = seed_valid;
    assign seed_o       = seed_word;

    // ------------------------------------------------------------------
    // Galois LFSR
    // ------------------------------------------------------------------
    logic [Width-1:0] lfsr_state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_state <= DefaultSeed;
        end else if (seed_valid) begin
            lfsr_state <= seed_word;
        end else if (lfsr_en_i) begin
            // An all-zero state (from a zero seed) would lock up forever.
            if (lfsr_state == '0) begin
                lfsr_state <= DefaultSeed;
            end else begin
                lfsr_state <= {1'b0, lfsr_state[Width-1:1]}
                            ^ ({Width{lfsr_state[0]}} & Taps);
            end
        end
    end

    assign state_raw_o = lfsr_state;

    // ------------------------------------------------------------------
    // Non-linear output: permutation then nibble-wise S-box
    // ------------------------------------------------------------------
    logic [Width-1:0] permuted;
    logic [Width-1:0] sboxed;

    always_comb begin
        permuted = '0;
        sboxed   = '0;
        for (int i = 0; i < Width; i++) begin
            permuted[i] = lfsr_state[StatePerm[i*6 +: 6]];
        end
        for (int j = 0; j < Width/4; j++) begin
            sboxed[4*j +: 4] = sbox(permuted[4*j +: 4]);
        end
    end

    assign state_o = sboxed;

endmodule
`default_nettype wire

// File: tb/tb_prng_lfsr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prng_lfsr_packer
// Description : Self-checking bench for prng_lfsr_packer. A queue-based
//               reference model predicts every output each cycle; directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prng_lfsr_packer;

    localparam logic [63:0] DEF = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        lfsr_en_i = 1'b0;
    logic        ent_valid_i = 1'b0;
    logic [31:0] ent_i = '0;
    logic        seed_valid_o;
    logic [63:0] seed_o;
    logic [63:0] state_raw_o;
    logic [63:0] state_o;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    prng_lfsr_packer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .lfsr_en_i    (lfsr_en_i),
        .ent_valid_i  (ent_valid_i),
        .ent_i        (ent_i),
        .seed_valid_o (seed_valid_o),
        .seed_o       (seed_o),
        .state_raw_o  (state_raw_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] beats[$];
    logic [63:0] m_state = DEF;
    logic        m_sv    = 1'b0;
    logic [63:0] m_seed  = '0;

    function automatic logic [63:0] poly_step(input logic [63:0] s);
        // Divide by x: shift toward bit 0, fold the dropped term back in.
        logic [63:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 64'hD800_0000_0000_0000;
        return r;
    endfunction

    function automatic logic [63:0] model_out(input logic [63:0] s);
        logic [3:0]  tbl [16];
        logic [63:0] r;
        tbl = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[4*j +: 4] = tbl[(s >> (4*j)) & 64'hF];
        end
        return r;
    endfunction

    task automatic model_edge();
        logic        nsv;
        logic [63:0] nseed;
        if (rst_i) begin
            m_state = DEF;
            beats.delete();
            m_sv   = 1'b0;
            m_seed = '0;
        end else begin
            if (m_sv)               m_state = m_seed;
            else if (lfsr_en_i)     m_state = (m_state == 0) ? DEF : poly_step(m_state);
            nsv   = 1'b0;
            nseed = '0;
            if (ent_valid_i) begin
                beats.push_back(ent_i);
                if (beats.size() == 2) begin
                    nsv   = 1'b1;
                    nseed = {beats[1], beats[0]};
                    beats.delete();
                end
            end
            m_sv   = nsv;
            m_seed = nseed;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, let the edge happen, advance the model,
    // return at the following falling edge.
    task automatic cyc(input logic rst, input logic en, input logic v, input logic [31:0] d);
        rst_i       = rst;
        lfsr_en_i   = en;
        ent_valid_i = v;
        ent_i       = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("state_raw", state_raw_o, m_state);
            check("state_out", state_o, model_out(m_state));
            check("seed_valid", {63'b0, seed_valid_o}, {63'b0, m_sv});
            check("seed", seed_o, m_seed);
        end
    end

    initial begin
        @(negedge clk);
        // 1. reset and hold
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        started = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        check("lit_reset_state", state_raw_o, DEF);
        check("lit_reset_sv", {63'b0, seed_valid_o}, 64'h0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("lit_hold_state", state_raw_o, DEF);

        // 2. seed = 1
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0001);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0000);
        check("lit_pulse", {63'b0, seed_valid_o}, 64'h1);
        check("lit_seed1", seed_o, 64'h1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("lit_state1", state_raw_o, 64'h1);
        check("lit_out1", state_o, 64'hBBBB_BBBB_BBBB_BBBF);
        check("lit_seed_cleared", seed_o, 64'h0);

        // 3. two steps
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_step1", state_raw_o, 64'hD800_0000_0000_0000);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_step2", state_raw_o, 64'h6C00_0000_0000_0000);

        // 4. zero seed and lockup recovery
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_zero_state", state_raw_o, 64'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_recover", state_raw_o, DEF);

        // 5. seed load has priority over a held step enable
        cyc(1'b0, 1'b1, 1'b1, 32'h1234_5678);
        cyc(1'b0, 1'b1, 1'b1, 32'h9ABC_DEF0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_prio", state_raw_o, 64'h9ABC_DEF0_1234_5678);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("lit_resume", state_raw_o, 64'h4D5E_6F78_091A_2B3C);

        // 6. back-to-back beats, third during the pulse
        cyc(1'b0, 1'b0, 1'b1, 32'hAAAA_0001);
        cyc(1'b0, 1'b0, 1'b1, 32'hBBBB_0002);
        check("lit_word_ba", seed_o, 64'hBBBB_0002_AAAA_0001);
        cyc(1'b0, 1'b0, 1'b1, 32'hCCCC_0003);
        check("lit_state_ba", state_raw_o, 64'hBBBB_0002_AAAA_0001);
        cyc(1'b0, 1'b0, 1'b1, 32'hDDDD_0004);
        check("lit_word_dc", seed_o, 64'hDDDD_0004_CCCC_0003);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);

        // reset mid-pack discards the partial word
        cyc(1'b0, 1'b0, 1'b1, 32'hAAAA_0001);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'hBBBB_0002);
        check("lit_no_pulse", {63'b0, seed_valid_o}, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'hCCCC_0003);
        check("lit_word_cb", seed_o, 64'hCCCC_0003_BBBB_0002);

        // gaps between beats plus free-running mix
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0);

        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prng_lfsr_packer.md
Name: prng_lfsr_packer

Overview:
- Reseedable 64-bit pseudo-random generator for secure register clearing.
- Packs narrow entropy beats into a 64-bit seed and loads it into a Galois-XOR LFSR.
- The output is the LFSR state after a bit permutation and a PRINCE S-box layer.
- Sits between the entropy (EDN-style) interface and data-path wipe consumers.

Parameters:
- Width, 64: LFSR/seed width; only 64 supported, elaboration error otherwise.
- EntropyWidth, 32: entropy beat width; must divide Width (Width/EntropyWidth beats per seed).
- DefaultSeed, 64'h0123_4567_89AB_CDEF: reset and lockup-recovery state; must be nonzero.
- StatePerm, identity: 64 entries of 6 bits each; permuted[i] = state[StatePerm[i]]; must be a bijection.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, synchronous and active-high.
- lfsr_en_i, in, 1: advance the LFSR one step this cycle.
- ent_valid_i, in, 1: entropy beat valid; always accepted, no ready.
- ent_i, in, EntropyWidth: entropy beat.
- seed_valid_o, out, 1: one-cycle pulse; the packed seed is loaded at this cycle's edge.
- seed_o, out, Width: packed seed; meaningful only while seed_valid_o is high.
- state_raw_o, out, Width: raw LFSR state.
- state_o, out, Width: non-linear output.

Behaviour:

Reset (rst_i=1 at an edge):
- state <= DefaultSeed.
- Packer emptied, beat count 0.
- seed_valid_o=0, seed_o=0.

LFSR step (lfsr_en_i=1, no seed load, state != 0):
- state <= {1'b0, state[63:1]} ^ ({64{state[0]}} & 64'hD800_0000_0000_0000).
- This is the Galois form of x^64+x^63+x^61+x^60+1.

Lockup recovery:
- If lfsr_en_i=1 and state==0 (only reachable by a zero seed), state <= DefaultSeed.

Seed load:
- When seed_valid_o=1, state <= seed_o at that edge.
- Seed load has priority over lfsr_en_i; no step occurs that cycle.

Packer:
- Each accepted beat k (k = 0 .. Width/EntropyWidth-1) is written to bits [k*EW +: EW]; first beat goes to the LSBs.
- The edge that accepts the final beat registers the word: seed_valid_o=1 and seed_o=word in the next cycle, for exactly one cycle.
- The consumer is always ready, so the packer empties as seed_valid_o is asserted.
- A beat arriving in the same cycle that seed_valid_o is high is accepted as beat 0 of the next word.
- No beat is ever dropped.
- seed_o returns to 0 when seed_valid_o falls.

Output function (combinational from state):
- p[i] = state[StatePerm[i]].
- Each nibble j of state_o is SBOX(p[4j+3:4j]).
- SBOX is the PRINCE S-box: 0..F -> B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4.

Timing and misc:
- Latency: last beat at edge t -> seed_valid_o high in cycle t..t+1 -> state equals seed after edge t+1.
- Reset mid-pack discards the partial word.
- ent_valid_i=0 cycles between beats are allowed; the partial word is held indefinitely.

Test Plan:
1. Reset, lfsr_en_i=0 -> state_raw_o=64'h0123_4567_89AB_CDEF, seed_valid_o=0; values held over 10 cycles.
2. Beats 32'h0000_0001 then 32'h0000_0000 -> seed_valid_o pulses for 1 cycle with seed_o=64'h1; next cycle state_raw_o=64'h1 and state_o=64'hBBBB_BBBB_BBBB_BBBF.
3. From state 1, lfsr_en_i=1 for one cycle -> state_raw_o=64'hD800_0000_0000_0000; a second step -> 64'h6C00_0000_0000_0000.
4. Seed all-zero (two zero beats), then lfsr_en_i=1 -> state 0 for one cycle, then state_raw_o=DefaultSeed.
5. lfsr_en_i=1 held while the seed pulse occurs -> no step that cycle; state equals the seed, then stepping resumes.
6. Beats A,B,C,D back-to-back with C arriving while seed_valid_o is high -> words {B,A} then {D,C}; two pulses, no beat lost. Also: reset after beat A -> a following B,C yields {C,B}.
